mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the RV32M extension.
// Ports: CLK, RESET (sync, active-high), START, FLUSH, SELECT (funct3),
//   DATA1 (rs1), DATA2 (rs2) in; BUSY, DONE (1-cycle pulse), RESULT out.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             FLUSH,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] a_orig;
  logic             neg_x;
  logic             neg_a;
  logic             b_zero;

  // Operand preparation: signedness per opcode, then magnitudes.
  logic             a_sgn;
  logic             b_sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_sgn = SELECT[2] ? ~SELECT[0] : (SELECT[1:0] != 2'b11);
    b_sgn = SELECT[2] ? ~SELECT[0] : ~SELECT[1];
    a_neg = a_sgn & DATA1[WIDTH-1];
    b_neg = b_sgn & DATA2[WIDTH-1];
    a_mag = a_neg ? -DATA1 : DATA1;
    b_mag = b_neg ? -DATA2 : DATA2;
  end

  // One iteration step.
  // Multiply: {hi,lo} holds partial product with multiplier in lo.
  // Divide: hi is the partial remainder, lo shifts dividend out and
  // quotient bits in.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic             unused_diff;

  always_comb begin
    mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_sh      = {hi, lo[WIDTH-1]};
    div_diff    = {1'b0, div_sh} - {2'b00, mcand};
    div_ok      = ~div_diff[WIDTH+1];
    unused_diff = div_diff[WIDTH];
  end

  // Sign correction and result selection.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    prod_s = neg_x ? -{hi, lo} : {hi, lo};
    q_s    = neg_x ? -lo : lo;
    r_s    = neg_a ? -hi : hi;
    if (!op[2]) begin
      fix_res = (op[1:0] == 2'b00) ? prod_s[WIDTH-1:0]
                                   : prod_s[2*WIDTH-1:WIDTH];
    end else if (b_zero) begin
      fix_res = op[1] ? a_orig : '1;
    end else begin
      fix_res = op[1] ? r_s : q_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START && !FLUSH) begin
            state  <= S_CALC;
            cnt    <= CW'(WIDTH);
            BUSY   <= 1'b1;
            op     <= SELECT;
            hi     <= '0;
            a_orig <= DATA1;
            neg_x  <= a_neg ^ b_neg;
            neg_a  <= a_neg;
            b_zero <= (DATA2 == '0);
            if (SELECT[2]) begin
              lo    <= a_mag;
              mcand <= b_mag;
            end else begin
              lo    <= b_mag;
              mcand <= a_mag;
            end
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            state <= S_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_FIX;
            if (op[2]) begin
              hi <= div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], div_ok};
            end else begin
              hi <= mul_sum[WIDTH:1];
              lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (FLUSH) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            state  <= S_DONE;
            RESULT <= fix_res;
            DONE   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
